// File: rtl/paddle_ctrl_if.sv
// Control/status bundle between the paddle controller and its driver:
// frame tick and button levels in, paddle row and activity flag out.
interface paddle_ctrl_if;
  logic       tick;
  logic       btn_up;
  logic       btn_down;
  logic [9:0] paddle_y;
  logic       moving;

  modport master (
    output tick,
    output btn_up,
    output btn_down,
    input  paddle_y,
    input  moving
  );

  modport slave (
    input  tick,
    input  btn_up,
    input  btn_down,
    output paddle_y,
    output moving
  );
endinterface

// File: rtl/paddle_ctrl.sv
// Paddle position controller: one step on press, then auto-repeat after a hold
// delay, clamped to [Y_MIN, Y_MAX].
module paddle_ctrl #(
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 400,
  parameter int Y_INIT     = 200,
  parameter int STEP       = 4,
  parameter int HOLD_TICKS = 15,
  parameter int RPT_TICKS  = 2
) (
  input  logic          clk,
  input  logic          reset,
  paddle_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;
  typedef enum logic [1:0] {DirNone, DirUp, DirDown} dir_e;

  localparam logic [7:0] LP_HOLD = 8'(HOLD_TICKS);
  localparam logic [7:0] LP_RPT  = 8'(RPT_TICKS);
  localparam logic [9:0] LP_YMIN = 10'(Y_MIN);
  localparam logic [9:0] LP_YMAX = 10'(Y_MAX);
  localparam logic [9:0] LP_YINI = 10'(Y_INIT);

  state_e     r_state;
  dir_e       r_dir_lat;
  logic [7:0] r_cnt;
  logic [9:0] r_paddle_y;
  logic       r_moving;

  dir_e       w_dir_req;
  int         w_y_sum;
  logic [9:0] w_y_step;
  logic       w_dir_hold;

  always_comb begin
    w_dir_req = DirNone;
    if (bus.btn_up && !bus.btn_down) begin
      w_dir_req = DirUp;
    end else if (bus.btn_down && !bus.btn_up) begin
      w_dir_req = DirDown;
    end
  end

  assign w_dir_hold = (w_dir_req == r_dir_lat);

  // Wide signed sum so the clamp sees the true value before truncation.
  always_comb begin
    w_y_sum  = 0;
    w_y_step = r_paddle_y;
    case (w_dir_req)
      DirUp: begin
        w_y_sum  = int'(r_paddle_y) - STEP;
        w_y_step = (w_y_sum < Y_MIN) ? LP_YMIN : 10'(w_y_sum);
      end
      DirDown: begin
        w_y_sum  = int'(r_paddle_y) + STEP;
        w_y_step = (w_y_sum > Y_MAX) ? LP_YMAX : 10'(w_y_sum);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_dir_lat  <= DirNone;
      r_cnt      <= 8'd0;
      r_paddle_y <= LP_YINI;
      r_moving   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_dir_req != DirNone) begin
            r_paddle_y <= w_y_step;
            r_dir_lat  <= w_dir_req;
            r_cnt      <= LP_HOLD;
            r_state    <= StDelay;
            r_moving   <= 1'b1;
          end
        end
        StDelay, StRepeat: begin
          // Release or direction change wins over a coincident tick.
          if (!w_dir_hold) begin
            r_state  <= StIdle;
            r_moving <= 1'b0;
          end else if (bus.tick) begin
            if (r_cnt == 8'd1) begin
              r_paddle_y <= w_y_step;
              r_cnt      <= LP_RPT;
              r_state    <= StRepeat;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        default: begin
          r_state  <= StIdle;
          r_moving <= 1'b0;
        end
      endcase
    end
  end

  assign bus.paddle_y = r_paddle_y;
  assign bus.moving   = r_moving;

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter Y_MIN, default 0: lowest legal paddle_y (top limit on screen).
REQ-002 Parameter Y_MAX, default 400: highest legal paddle_y (bottom limit).
REQ-003 Parameter Y_INIT, default 200: paddle_y after reset; Y_MIN <= Y_INIT <= Y_MAX.
REQ-004 Parameter STEP, default 4: pixels moved per step; 1..63.
REQ-005 Parameter HOLD_TICKS, default 15: ticks held before auto-repeat starts; >= 1.
REQ-006 Parameter RPT_TICKS, default 2: ticks between auto-repeat steps; >= 1.
REQ-007 clk  in  1  single system clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 tick  in  1  one-cycle frame strobe (e.g. once per vertical frame).
REQ-010 btn_up  in  1  debounced level, 1 = up button held.
REQ-011 btn_down  in  1  debounced level, 1 = down button held.
REQ-012 paddle_y  out  10  registered paddle top-edge row.
REQ-013 moving  out  1  registered; 1 while a press is being serviced (state != IDLE).

Function
REQ-014 Requested direction dir_req SHALL be UP if btn_up=1 and btn_down=0, DOWN if btn_down=1 and btn_up=0, NONE otherwise (both or neither).
REQ-015 FSM SHALL have states IDLE, DELAY, REPEAT, plus a latched direction dir_lat and a tick counter cnt (>= 8 bits).
REQ-016 IDLE: if dir_req != NONE, SHALL perform one step in dir_lat := dir_req on that edge (paddle_y updates 1 cycle after first sampled press), load cnt := HOLD_TICKS, go to DELAY; else stay IDLE.
REQ-017 DELAY: if dir_req != dir_lat, SHALL go to IDLE with no step; else on tick with cnt == 1 SHALL step, load cnt := RPT_TICKS, go to REPEAT; else on tick SHALL decrement cnt.
REQ-018 REPEAT: if dir_req != dir_lat, SHALL go to IDLE with no step; else on tick with cnt == 1 SHALL step and reload cnt := RPT_TICKS; else on tick SHALL decrement cnt.
REQ-019 Direction release or change in the same cycle as tick SHALL take priority: no step, transition to IDLE.
REQ-020 Reversal (UP to DOWN held continuously) SHALL take exactly two cycles: DELAY/REPEAT -> IDLE, then IDLE steps in the new direction.
REQ-021 UP step SHALL set paddle_y := max(paddle_y - STEP, Y_MIN); DOWN step SHALL set paddle_y := min(paddle_y + STEP, Y_MAX).
REQ-022 Step arithmetic SHALL use at least 11-bit signed intermediates so that no underflow or overflow wrap ever occurs; paddle_y SHALL never leave [Y_MIN, Y_MAX].
REQ-023 A step at a limit SHALL leave paddle_y unchanged; the FSM SHALL still sequence normally (moving stays 1 while held).
REQ-024 tick while IDLE SHALL have no effect; cnt SHALL change only on tick in DELAY/REPEAT or on load.
REQ-025 moving SHALL be 1 in DELAY and REPEAT, 0 in IDLE, registered with the state.

Reset
REQ-026 While reset=1 at a clock edge: paddle_y := Y_INIT, state := IDLE, dir_lat := NONE, cnt := 0, moving := 0; reset SHALL override all other inputs.
REQ-027 Reset mid-DELAY/REPEAT SHALL abort the press; if a button is still held after reset deasserts, IDLE SHALL treat it as a new press (one step on the first post-reset edge).

Verification
REQ-028 Reset asserted 2 cycles, buttons 0 -> paddle_y=200, moving=0; 100 ticks with no buttons -> paddle_y stays 200.
REQ-029 btn_up high for 3 cycles, no tick -> paddle_y=196 one cycle after first high sample, moving=1 for those cycles, back to 0 and paddle_y stays 196.
REQ-030 btn_down held from y=200 -> 204 immediately, 208 at 15th tick, then +4 every 2nd tick (212 at tick 17, 216 at tick 19).
REQ-031 Clamp: hold down from y=398 -> 400 and never above; hold up from y=2 -> 0 and never wraps; moving stays 1.
REQ-032 Both buttons high -> no change, moving=0; up held in REPEAT then switched to down -> one IDLE cycle, then +4 step, DELAY restarts.
REQ-033 Reset pulsed during REPEAT with btn_down held -> paddle_y=200 on reset edge, 204 on first edge after reset deasserts.
